// File: rtl/step_pulse_generator.sv
// Stepper-motor step pulse generator with trapezoidal/triangular rate profile.
// Latency: first step rises 1+DIR_SETUP cycles after start; done pulses the cycle after the last period ends.
// Backpressure: none; start is ignored while a move is active, stop aborts into DONE on the next cycle.
//
// Ports:
//   clk, reset (sync, active-low)    - clock and reset
//   start, stop                      - move request / abort
//   new_par[0:4]                     - {N, nn, t0, tna, delta}; delta is signed
//   dir_in                           - requested direction, latched on start
//   step, dir                        - driver outputs
//   busy, done                       - move in progress / one-cycle completion pulse
//   step_cnt                         - steps issued in the current or last move
module step_pulse_generator #(
  parameter int PULSE_WIDTH = 10,
  parameter int DIR_SETUP   = 5,
  parameter int MIN_PERIOD  = 2 * PULSE_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] new_par [0:4],
  input  logic        dir_in,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done,
  output logic [31:0] step_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  localparam logic [31:0]        PW         = 32'(PULSE_WIDTH);
  localparam logic [31:0]        SETUP_LAST = 32'(DIR_SETUP - 1);
  localparam logic signed [63:0] MIN_P      = 64'(MIN_PERIOD);

  state_t             state_q, state_d;
  logic [31:0]        n_q, n_d, nn_q, nn_d, t0_q, t0_d, tna_q, tna_d, delta_q, delta_d;
  logic [31:0]        m_q, m_d;          // ramp index min(k, N-1-k) of the current step
  logic [31:0]        cnt_q, cnt_d;      // cycle counter within SETUP or within a step period
  logic [31:0]        step_cnt_q, step_cnt_d;
  logic signed [63:0] nom_q, nom_d;      // t0 + m*delta, maintained by add/subtract only
  logic               step_q, step_d, dir_q, dir_d;

  logic signed [63:0] t0_s, tna_s, delta_s, lo_s, hi_s, sel_s, clamp_s;
  logic [63:0]        period;
  logic               period_end, last_step, ramp_up, ramp_flat;

  // Period of the current step, from the ramp state and latched parameters.
  always_comb begin
    t0_s    = {32'd0, t0_q};
    tna_s   = {32'd0, tna_q};
    delta_s = {{32{delta_q[31]}}, delta_q};
    lo_s    = (t0_s < tna_s) ? t0_s : tna_s;
    hi_s    = (t0_s < tna_s) ? tna_s : t0_s;
    sel_s   = (m_q < nn_q) ? nom_q : tna_s;
    clamp_s = sel_s;
    if (sel_s < lo_s) begin
      clamp_s = lo_s;
    end else if (sel_s > hi_s) begin
      clamp_s = hi_s;
    end
    if (clamp_s < MIN_P) begin
      clamp_s = MIN_P;
    end
    period     = clamp_s;
    period_end = ({32'd0, cnt_q} + 64'd1) == period;
    last_step  = (step_cnt_q == n_q);
    // With step_cnt = k+1 steps issued: m rises while 2k+3 <= N, holds at the
    // even-N midpoint (2k+2 == N), and falls otherwise.
    ramp_up    = ({1'b0, step_cnt_q, 1'b0} + 34'd1) <= {2'b00, n_q};
    ramp_flat  = {1'b0, step_cnt_q, 1'b0} == {2'b00, n_q};
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    nn_d       = nn_q;
    t0_d       = t0_q;
    tna_d      = tna_q;
    delta_d    = delta_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    nom_d      = nom_q;
    step_d     = step_q;
    dir_d      = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = new_par[0];
          nn_d       = new_par[1];
          t0_d       = new_par[2];
          tna_d      = new_par[3];
          delta_d    = new_par[4];
          dir_d      = dir_in;
          step_cnt_d = 32'd0;
          cnt_d      = 32'd0;
          m_d        = 32'd0;
          nom_d      = {32'd0, new_par[2]};
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (stop) begin
          step_d  = 1'b0;
          state_d = DONE;
        end else if (n_q == 32'd0) begin
          state_d = DONE;
        end else if (cnt_q == SETUP_LAST) begin
          // Step is registered, so it rises on the first RUN cycle.
          cnt_d      = 32'd0;
          step_d     = 1'b1;
          step_cnt_d = 32'd1;
          state_d    = RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (stop) begin
          step_d  = 1'b0;
          state_d = DONE;
        end else if (period_end) begin
          if (last_step) begin
            step_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d      = 32'd0;
            step_d     = 1'b1;
            step_cnt_d = step_cnt_q + 32'd1;
            if (ramp_up) begin
              m_d   = m_q + 32'd1;
              nom_d = nom_q + delta_s;
            end else if (!ramp_flat) begin
              m_d   = m_q - 32'd1;
              nom_d = nom_q - delta_s;
            end
          end
        end else begin
          cnt_d  = cnt_q + 32'd1;
          step_d = (cnt_q + 32'd1) < PW;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= 32'd0;
      nn_q       <= 32'd0;
      t0_q       <= 32'd0;
      tna_q      <= 32'd0;
      delta_q    <= 32'd0;
      m_q        <= 32'd0;
      cnt_q      <= 32'd0;
      step_cnt_q <= 32'd0;
      nom_q      <= 64'sd0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      nn_q       <= nn_d;
      t0_q       <= t0_d;
      tna_q      <= tna_d;
      delta_q    <= delta_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      nom_q      <= nom_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign busy     = (state_q == SETUP) || (state_q == RUN);
  assign done     = (state_q == DONE);
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_step_pulse_generator.sv
// Self-checking bench for step_pulse_generator: profile timing against a
// closed-form period model, abort, reset, ignored start and start+stop.
// Inputs change 1 time unit after the rising edge; outputs are logged on the falling edge.
module tb_step_pulse_generator;
  localparam int PW   = 10;
  localparam int DS   = 5;
  localparam int MINP = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir_in = 1'b0;
  logic [31:0] new_par [0:4];
  logic        step, dir, busy, done;
  logic [31:0] step_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int          rise_q[$];
  int          fall_q[$];
  int          done_q[$];
  logic [31:0] cnt_at_rise_q[$];
  int          busy_cycles = 0;
  int          dir_err = 0;
  logic        exp_dir = 1'b0;
  logic        prev_step = 1'b0;

  step_pulse_generator #(.PULSE_WIDTH(PW), .DIR_SETUP(DS), .MIN_PERIOD(MINP)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .new_par(new_par),
    .dir_in(dir_in), .step(step), .dir(dir), .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step === 1'b1 && prev_step !== 1'b1) begin
      rise_q.push_back(cyc);
      cnt_at_rise_q.push_back(step_cnt);
    end
    if (step === 1'b0 && prev_step === 1'b1) fall_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) begin
      busy_cycles++;
      if (dir !== exp_dir) dir_err++;
    end
    prev_step = step;
  end

  // Reference period of step k straight from the profile rules.
  function automatic longint ref_period(longint k, longint n, longint nn, longint t0,
                                        longint tna, longint delta);
    longint m, p, lo, hi;
    m  = (k < n - 1 - k) ? k : n - 1 - k;
    p  = (m < nn) ? t0 + m * delta : tna;
    lo = (t0 < tna) ? t0 : tna;
    hi = (t0 < tna) ? tna : t0;
    if (p < lo) p = lo;
    if (p > hi) p = hi;
    if (p < MINP) p = MINP;
    return p;
  endfunction

  task automatic launch(input longint n, input longint nn, input longint t0, input longint tna,
                        input longint delta, input logic d, input logic with_stop, output int sc);
    @(posedge clk); #1;
    rise_q.delete(); fall_q.delete(); done_q.delete(); cnt_at_rise_q.delete();
    busy_cycles = 0; dir_err = 0; exp_dir = d;
    new_par[0] = n[31:0]; new_par[1] = nn[31:0]; new_par[2] = t0[31:0];
    new_par[3] = tna[31:0]; new_par[4] = delta[31:0];
    dir_in = d; start = 1'b1; stop = with_stop; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; dir_in = ~d;
    foreach (new_par[i]) new_par[i] = $urandom;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int cnt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rise_q.size() >= cnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; dir_in = 1'b1;
    foreach (new_par[i]) new_par[i] = 32'd40;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({step, dir, busy, done} !== 4'b0000) begin n_err++;
      $display("FAIL reset_outputs: got %b want 0000", {step, dir, busy, done}); end
    n_cmp++; if (step_cnt !== 32'd0) begin n_err++;
      $display("FAIL reset_step_cnt: got %0d want 0", step_cnt); end
    reset = 1'b1; start = 1'b0; busy_cycles = 0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy_cycles !== 0) begin n_err++;
      $display("FAIL reset_start_ignored: busy cycles %0d want 0", busy_cycles); end
  endtask

  task automatic test_profiles;
    longint tab[5][5] = '{'{5, 2, 100, 60, -20}, '{0, 3, 50, 50, 0}, '{3, 0, 100, 5, 0},
                          '{6, 10, 30, 70, 15}, '{4, 1, 40, 90, 25}};
    longint n, nn, t0, tna, delta, t;
    int     exp_rise[$];
    int     sc, exp_done, lim;
    bit     ok;
    logic   d;
    for (int it = 0; it < 17; it++) begin
      if (it < 5) begin
        n = tab[it][0]; nn = tab[it][1]; t0 = tab[it][2]; tna = tab[it][3]; delta = tab[it][4];
      end else begin
        n = $urandom_range(8); nn = $urandom_range(5);
        t0 = 1 + $urandom_range(89); tna = 1 + $urandom_range(89);
        delta = longint'($urandom_range(60)) - 30;
      end
      d = 1'($urandom_range(1));
      launch(n, nn, t0, tna, delta, d, 1'b0, sc);
      exp_rise.delete();
      t = sc + 1 + DS;
      for (longint k = 0; k < n; k++) begin
        exp_rise.push_back(int'(t));
        t += ref_period(k, n, nn, t0, tna, delta);
      end
      exp_done = (n == 0) ? sc + 2 : int'(t);
      wait_done(2000, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (!ok) begin n_err++;
        $display("FAIL prof%0d_timeout: no done within budget", it); end
      n_cmp++; if (rise_q.size() != n) begin n_err++;
        $display("FAIL prof%0d_pulses: got %0d want %0d", it, rise_q.size(), n); end
      lim = (rise_q.size() < n) ? rise_q.size() : int'(n);
      for (int k = 0; k < lim; k++) begin
        n_cmp++; if (rise_q[k] != exp_rise[k]) begin n_err++;
          $display("FAIL prof%0d_rise%0d: at %0d want %0d", it, k, rise_q[k], exp_rise[k]); end
        n_cmp++; if (k >= fall_q.size() || fall_q[k] - rise_q[k] != PW) begin n_err++;
          $display("FAIL prof%0d_width%0d: fall missing or width wrong, want %0d", it, k, PW); end
        n_cmp++; if (cnt_at_rise_q[k] !== 32'(k + 1)) begin n_err++;
          $display("FAIL prof%0d_cnt_at_rise%0d: got %0d want %0d", it, k, cnt_at_rise_q[k], k + 1); end
      end
      n_cmp++; if (done_q.size() != 1 || done_q[0] != exp_done) begin n_err++;
        $display("FAIL prof%0d_done: %0d pulses, first at %0d want one at %0d", it, done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, exp_done); end
      n_cmp++; if (busy_cycles != exp_done - sc - 1) begin n_err++;
        $display("FAIL prof%0d_busy: got %0d cycles want %0d", it, busy_cycles, exp_done - sc - 1); end
      n_cmp++; if (step_cnt !== n[31:0]) begin n_err++;
        $display("FAIL prof%0d_step_cnt: got %0d want %0d", it, step_cnt, n); end
      n_cmp++; if (dir_err != 0) begin n_err++;
        $display("FAIL prof%0d_dir: %0d busy cycles with dir != %b", it, dir_err, exp_dir); end
    end
  endtask

  task automatic test_abort;
    int offs[2] = '{10, 3};
    int nrise[2] = '{4, 2};
    int sc, r, stop_c;
    bit ok;
    for (int j = 0; j < 2; j++) begin
      launch(100, 0, 50, 50, 0, 1'b1, 1'b0, sc);
      wait_rises(nrise[j], 600, ok);
      n_cmp++; if (!ok) begin n_err++;
        $display("FAIL abort%0d_timeout: only %0d rises", j, rise_q.size()); end
      r = (rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : cyc;
      while (cyc < r + offs[j]) begin @(posedge clk); #1; end
      stop = 1'b1; stop_c = cyc;
      @(posedge clk); #1;
      stop = 1'b0;
      n_cmp++; if (step !== 1'b0) begin n_err++;
        $display("FAIL abort%0d_step_low: got %b want 0", j, step); end
      wait_done(20, ok);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (done_q.size() != 1 || done_q[0] != stop_c + 1) begin n_err++;
        $display("FAIL abort%0d_done: %0d pulses, want one at %0d", j, done_q.size(), stop_c + 1); end
      n_cmp++; if (step_cnt !== 32'(nrise[j]) || rise_q.size() != nrise[j]) begin n_err++;
        $display("FAIL abort%0d_count: step_cnt %0d rises %0d want %0d", j, step_cnt, rise_q.size(), nrise[j]); end
      if (j == 1) begin
        n_cmp++; if (fall_q.size() != 2 || fall_q[1] != stop_c + 1) begin n_err++;
          $display("FAIL abort%0d_fall: falls %0d, want second at %0d", j, fall_q.size(), stop_c + 1); end
      end
    end
  endtask

  task automatic test_reset_mid_move;
    int sc;
    bit ok;
    launch(5, 2, 100, 60, -20, 1'b1, 1'b0, sc);
    wait_rises(2, 400, ok);
    n_cmp++; if (!ok) begin n_err++;
      $display("FAIL rstmid_timeout: only %0d rises", rise_q.size()); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({step, dir, busy, done} !== 4'b0000 || step_cnt !== 32'd0) begin n_err++;
      $display("FAIL rstmid_outputs: got %b cnt %0d want 0000 cnt 0", {step, dir, busy, done}, step_cnt); end
    reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    n_cmp++; if (done_q.size() != 0 || rise_q.size() != 2) begin n_err++;
      $display("FAIL rstmid_quiet: done %0d rises %0d want 0 and 2", done_q.size(), rise_q.size()); end
    launch(3, 1, 30, 30, 0, 1'b1, 1'b0, sc);
    wait_done(300, ok);
    #1;
    n_cmp++; if (!ok || done_q[0] != sc + 1 + DS + 90 || rise_q.size() != 3) begin n_err++;
      $display("FAIL rstmid_rerun: done ok=%0b rises %0d want done at %0d and 3 rises", ok, rise_q.size(), sc + 1 + DS + 90); end
    n_cmp++; if (step_cnt !== 32'd3) begin n_err++;
      $display("FAIL rstmid_rerun_cnt: got %0d want 3", step_cnt); end
  endtask

  task automatic test_ignored_start;
    int sc, base;
    bit ok;
    launch(4, 2, 60, 30, -15, 1'b0, 1'b0, sc);
    base = sc + 1 + DS;
    wait_rises(2, 400, ok);
    new_par[0] = 32'd9; new_par[1] = 32'd0; new_par[2] = 32'd25;
    new_par[3] = 32'd25; new_par[4] = 32'd0;
    dir_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(600, ok);
    repeat (300) @(posedge clk);
    #1;
    n_cmp++; if (rise_q.size() != 4) begin n_err++;
      $display("FAIL ign_pulses: got %0d want 4", rise_q.size()); end
    n_cmp++; if (rise_q.size() < 4 || rise_q[2] != base + 105 || rise_q[3] != base + 150) begin n_err++;
      $display("FAIL ign_profile: late rises not at %0d and %0d", base + 105, base + 150); end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != base + 210) begin n_err++;
      $display("FAIL ign_done: %0d pulses, want one at %0d", done_q.size(), base + 210); end
    n_cmp++; if (dir_err != 0 || busy !== 1'b0) begin n_err++;
      $display("FAIL ign_dir_busy: dir errs %0d busy %b want 0 0", dir_err, busy); end
  endtask

  task automatic test_start_stop_idle;
    int sc;
    bit ok;
    launch(2, 1, 40, 40, 0, 1'b1, 1'b1, sc);
    wait_done(300, ok);
    #1;
    n_cmp++; if (!ok || done_q[0] != sc + 1 + DS + 80) begin n_err++;
      $display("FAIL startstop_done: ok=%0b want done at %0d", ok, sc + 1 + DS + 80); end
    n_cmp++; if (step_cnt !== 32'd2) begin n_err++;
      $display("FAIL startstop_cnt: got %0d want 2", step_cnt); end
  endtask

  initial begin
    foreach (new_par[i]) new_par[i] = 32'd0;
    test_reset();
    test_profiles();
    test_abort();
    test_reset_mid_move();
    test_ignored_start();
    test_start_stop_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule

// File: doc/step_pulse_generator.md
STEP_PULSE_GENERATOR -- requirements
Module: step_pulse_generator

Interface
REQ-001 SHALL have parameter PULSE_WIDTH, default 10, giving the step-high duration in clk cycles.
REQ-002 SHALL have parameter DIR_SETUP, default 5, giving the number of clk cycles dir is held stable before the first step.
REQ-003 SHALL have parameter MIN_PERIOD, default 2*PULSE_WIDTH, giving the smallest step period in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to load a move.
REQ-007 SHALL have port stop, input, 1 bit: aborts the move in progress.
REQ-008 SHALL have port new_par, input, 32 bits x [0:4]: motion parameters {N, nn, t0, tna, delta}, as produced by the upstream parameter calculator.
REQ-009 SHALL have port dir_in, input, 1 bit: requested direction.
REQ-010 SHALL have port step, output, 1 bit: step pulse to the driver.
REQ-011 SHALL have port dir, output, 1 bit: direction to the driver.
REQ-012 SHALL have port busy, output, 1 bit: high while a move is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle move-complete pulse.
REQ-014 SHALL have port step_cnt, output, 32 bits: number of steps issued in the current or last move.

Function
REQ-015 SHALL implement the states IDLE, SETUP, RUN and DONE.
REQ-016 SHALL, in IDLE with start=1, latch new_par and dir_in, clear step_cnt, assert busy and drive dir from the next cycle, and enter SETUP.
REQ-017 SHALL ignore start whenever the state is not IDLE; the latched parameters SHALL stay unchanged.
REQ-018 SHALL go SETUP->DONE after 1 cycle if N=0, otherwise SETUP->RUN after DIR_SETUP cycles.
REQ-019 SHALL produce the first step rising edge exactly 1+DIR_SETUP cycles after the start cycle.
REQ-020 SHALL derive, for step index k (0..N-1), a value m = min(k, N-1-k).
REQ-021 SHALL use a nominal step-k period of t0 + m*delta when m < nn, and tna otherwise.
REQ-022 SHALL treat delta as signed two's complement and evaluate the period in at least 34-bit signed arithmetic.
REQ-023 SHALL clamp the nominal period to the range [min(t0,tna), max(t0,tna)] and then raise it to at least MIN_PERIOD.
REQ-024 SHALL compute periods incrementally; no divider or multiplier SHALL be used in the step loop.
REQ-025 SHALL drive step high for the first PULSE_WIDTH cycles of each period and low for the remainder of it.
REQ-026 SHALL increment step_cnt on the same cycle that step rises.
REQ-027 SHALL keep consecutive periods back-to-back, with no idle cycles between steps.
REQ-028 SHALL move RUN->DONE on the last cycle of step N-1's period.
REQ-029 SHALL, in DONE, assert done for exactly 1 cycle, deassert busy in that same cycle, and return to IDLE.
REQ-030 SHALL, on stop=1 in SETUP or RUN, drive step low next cycle and enter DONE; step_cnt SHALL keep the number of steps already issued.
REQ-031 SHALL treat start and stop asserted in the same cycle in IDLE as start only; stop SHALL be ignored in IDLE.
REQ-032 SHALL, when nn=0, run every step at the tna period (after clamping).
REQ-033 SHALL, when 2*nn exceeds N, give a symmetric triangle profile per REQ-020..REQ-023 with no cruise segment.
REQ-034 SHALL hold dir constant from SETUP until done.

Reset
REQ-035 SHALL, when reset=0 at a clk edge, force step=0, dir=0, busy=0, done=0, step_cnt=0 and state IDLE at that edge, including mid-move.
REQ-036 SHALL ignore start in any cycle where reset=0.
REQ-037 SHALL NOT emit a done pulse as a result of reset.

Verification
REQ-038 Profile check: N=5, nn=2, t0=100, tna=60, delta=-20 -> periods 100, 80, 60, 80, 100; each step high 10 cycles; done exactly 420 cycles after the first step rise; step_cnt=5.
REQ-039 Zero move: N=0 -> no step pulses; done 2 cycles after start; busy high for exactly 1 cycle.
REQ-040 Floor clamp: N=3, nn=0, tna=5 -> every period raised to 20 (MIN_PERIOD); 3 pulses.
REQ-041 Abort: N=100, t0=tna=50, stop asserted 10 cycles after the 4th step rise -> step low next cycle; done pulse; step_cnt=4.
REQ-042 Reset mid-move: reset=0 during RUN -> all outputs 0 at that edge; a start issued after reset releases runs a full move normally.
REQ-043 Ignored start: start pulsed during RUN with different new_par -> the current profile is unchanged and no second move follows.
